// File: rtl/risc_controller_pkg.sv
// Shared definitions for the 8-bit RISC sequencer: opcode and phase encodings,
// widths, and the strobe bundle the controller decodes.
package risc_controller_pkg;

  localparam int unsigned OPWIDTH = 3;
  localparam int unsigned PHASES  = 8;
  localparam int unsigned PHWIDTH = $clog2(PHASES);

  typedef enum logic [OPWIDTH-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PHWIDTH-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_phase_counter.sv
// Free-running instruction phase counter; holds while en_i is low and wraps at
// the last phase back to INST_ADDR.
module risc_phase_counter
  import risc_controller_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               en_i,
  output logic [PHWIDTH-1:0] phase_o
);

  logic [PHWIDTH-1:0] phase_q;
  logic [PHWIDTH-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (en_i) begin
      if (phase_q == PHWIDTH'(PHASES - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PHWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/risc_controller.sv
// Sequencing controller for the 8-bit RISC datapath: decodes the registered
// phase, opcode and zero flag into datapath strobes; HLT freezes it until clr.
module risc_controller
  import risc_controller_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic [OPWIDTH-1:0] opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic [PHWIDTH-1:0] phase
);

  logic    halted_q;
  logic    halted_d;
  logic    alu_op;
  opcode_e op;
  phase_e  ph;
  ctrl_t   ctrl;

  // The counter must not advance on the edge that takes the HLT, so it is
  // gated by the next-state halted flag rather than the registered one.
  risc_phase_counter u_phase_counter (
    .clk     (clk),
    .clr     (clr),
    .en_i    (~halted_d),
    .phase_o (phase)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ctrl     = '0;
    halted_d = halted_q;
    op       = opcode_e'(opcode);
    ph       = phase_e'(phase);
    alu_op   = is_aluop(op);

    if (halted_q) begin
      ctrl.halt = 1'b1;
    end else begin
      unique case (ph)
        PH_INST_ADDR: begin
          ctrl.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        // IR is loaded twice with the same byte; harmless and keeps rd steady.
        PH_INST_LOAD, PH_IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          if (op == OP_HLT) begin
            ctrl.halt = 1'b1;
            halted_d  = 1'b1;
          end
        end
        PH_OP_FETCH: begin
          ctrl.rd = alu_op;
        end
        PH_ALU_OP: begin
          ctrl.rd     = alu_op;
          ctrl.inc_pc = (op == OP_SKZ) && zero;
          ctrl.ld_pc  = (op == OP_JMP);
          ctrl.data_e = (op == OP_STO);
        end
        PH_STORE: begin
          ctrl.rd     = alu_op;
          ctrl.ld_ac  = alu_op;
          ctrl.ld_pc  = (op == OP_JMP);
          ctrl.wr     = (op == OP_STO);
          ctrl.data_e = (op == OP_STO);
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign ld_ir  = ctrl.ld_ir;
  assign inc_pc = ctrl.inc_pc;
  assign ld_pc  = ctrl.ld_pc;
  assign ld_ac  = ctrl.ld_ac;
  assign wr     = ctrl.wr;
  assign data_e = ctrl.data_e;
  assign halt   = ctrl.halt;

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: an independent reference of the phase
// sequence and strobe table feeds a scoreboard checked every cycle.
module tb_risc_controller;

  logic       clk;
  logic       clr;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  logic [11:0] sb[$];
  logic [2:0]  m_phase;
  logic        m_halted;

  risc_controller dut (
    .clk    (clk),
    .clr    (clr),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,phase}.
  function automatic logic [11:0] model_out(input logic [2:0] ph, input logic [2:0] op,
                                            input logic z, input logic hlt);
    logic s, r, li, ip, lp, la, w, de, h, alu;
    s = 0; r = 0; li = 0; ip = 0; lp = 0; la = 0; w = 0; de = 0; h = 0;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    if (hlt) begin
      h = 1;
    end else begin
      case (ph)
        3'd0: s = 1;
        3'd1: begin s = 1; r = 1; end
        3'd2, 3'd3: begin s = 1; r = 1; li = 1; end
        3'd4: begin ip = 1; h = (op == 3'd0); end
        3'd5: r = alu;
        3'd6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6); end
        default: begin
          r = alu; la = alu; lp = (op == 3'd7); w = (op == 3'd6); de = (op == 3'd6);
        end
      endcase
    end
    return {s, r, li, ip, lp, la, w, de, h, ph};
  endfunction

  task automatic check(input string tag);
    logic [11:0] exp_v, act_v;
    act_v = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %03h expected <scoreboard empty>", tag, act_v);
    end else begin
      exp_v = sb.pop_front();
      assert (act_v === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %03h expected %03h (phase %0d)", tag, act_v, exp_v, m_phase);
      end
    end
  endtask

  // Called at posedge+1: drive, predict, sample at negedge, step through the next edge.
  task automatic run_cycles(input string tag, input logic [2:0] op, input logic z,
                            input int n, input bit rand_op);
    logic [2:0] cur;
    for (int i = 0; i < n; i++) begin
      cur = rand_op ? 3'($urandom_range(7, 0)) : op;
      opcode = cur;
      zero   = z;
      #1;
      sb.push_back(model_out(m_phase, cur, z, m_halted));
      @(negedge clk);
      check(tag);
      @(posedge clk);
      if (!m_halted) begin
        if (m_phase == 3'd4 && cur == 3'd0) m_halted = 1'b1;
        else m_phase = m_phase + 3'd1;
      end
      #1;
    end
  endtask

  // Asynchronous reset asserted between edges, held across one edge, released at posedge+1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    clr = 1'b1;
    m_phase  = 3'd0;
    m_halted = 1'b0;
    #1;
    sb.push_back(model_out(m_phase, opcode, zero, m_halted));
    check({tag, "_async"});
    @(posedge clk);
    #1;
    sb.push_back(model_out(m_phase, opcode, zero, m_halted));
    check({tag, "_held"});
    clr = 1'b0;
  endtask

  initial begin
    clr      = 1'b1;
    opcode   = 3'd2;
    zero     = 1'b0;
    m_phase  = 3'd0;
    m_halted = 1'b0;
    #2;
    sb.push_back(model_out(3'd0, 3'd2, 1'b0, 1'b0));
    check("reset_initial");
    @(posedge clk);
    #1;
    clr = 1'b0;

    run_cycles("add_seq", 3'd2, 1'b0, 9, 1'b0);
    run_cycles("add_tail", 3'd2, 1'b0, 7, 1'b0);
    run_cycles("fetch_opnoise", 3'd0, 1'b0, 4, 1'b1);
    run_cycles("add_after_noise", 3'd2, 1'b1, 4, 1'b0);
    run_cycles("sto", 3'd6, 1'b0, 8, 1'b0);
    run_cycles("skz_zero1", 3'd1, 1'b1, 8, 1'b0);
    run_cycles("skz_zero0", 3'd1, 1'b0, 8, 1'b0);
    run_cycles("jmp", 3'd7, 1'b1, 8, 1'b0);
    run_cycles("xor", 3'd4, 1'b1, 8, 1'b0);
    run_cycles("and", 3'd3, 1'b0, 8, 1'b0);
    run_cycles("lda", 3'd5, 1'b0, 8, 1'b0);

    run_cycles("add_partial", 3'd2, 1'b0, 6, 1'b0);
    do_reset("reset_mid");
    run_cycles("add_resume", 3'd2, 1'b0, 8, 1'b0);

    run_cycles("hlt_enter", 3'd0, 1'b0, 5, 1'b0);
    run_cycles("halted_hold", 3'd0, 1'b1, 20, 1'b1);
    do_reset("reset_halt");
    run_cycles("after_halt", 3'd2, 1'b0, 9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
